// File: rtl/direction_input_ctrl_if.sv
// Board push-button inputs and the direction/start controls handed to the movement FSM.
interface direction_input_ctrl_if;
    logic BtnL, BtnU, BtnR, BtnD, BtnC;
    logic Left, Up, Right, Down, centerPulse;

    modport master (
        output BtnL, BtnU, BtnR, BtnD, BtnC,
        input  Left, Up, Right, Down, centerPulse
    );

    modport slave (
        input  BtnL, BtnU, BtnR, BtnD, BtnC,
        output Left, Up, Right, Down, centerPulse
    );
endinterface

// File: rtl/direction_input_ctrl.sv
// Button front end: 2-flop sync + debounce per button, last-press-wins direction arbiter,
// and a single-cycle pulse for the centre button.
module direction_input_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic db_o,
    output logic flip_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q;
    logic             mism;

    assign mism   = sync_q[1] ^ db_q;
    // flip_o is the level change that lands on this edge; the arbiter needs it early
    assign flip_o = mism && (cnt_q == CNT_MAX);
    assign db_o   = db_q;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!mism || flip_o) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            db_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            cnt_q  <= cnt_d;
            db_q   <= db_q ^ flip_o;
        end
    end
endmodule

module direction_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                  clk,
    input  logic                  reset,
    direction_input_ctrl_if.slave bus
);
    localparam int NUM_BTN = 5;
    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [2:0] {OWN_NONE, OWN_L, OWN_U, OWN_R, OWN_D} own_e;

    // bit order: 0=L 1=U 2=R 3=D 4=C
    logic [NUM_BTN-1:0] raw, db_q, flip;
    logic [3:0]         db_d, rise;
    own_e               own_q, own_d;
    logic [3:0]         dir_q;
    logic               dbc_dly_q, pulse_q;

    assign raw = {bus.BtnC, bus.BtnD, bus.BtnR, bus.BtnU, bus.BtnL};

    generate
        for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
            direction_input_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_db (
                .clk   (clk),
                .reset (reset),
                .raw_i (raw[g]),
                .db_o  (db_q[g]),
                .flip_o(flip[g])
            );
        end
    endgenerate

    assign db_d = db_q[3:0] ^ flip[3:0];
    assign rise = flip[3:0] & ~db_q[3:0];

    function automatic own_e pick(input logic [3:0] v);
        own_e r;
        r = OWN_NONE;
        if (v[3]) r = OWN_D;
        if (v[2]) r = OWN_R;
        if (v[1]) r = OWN_U;
        if (v[0]) r = OWN_L;
        return r;
    endfunction

    function automatic logic [3:0] own_oh(input own_e o);
        logic [3:0] r;
        r = 4'b0000;
        case (o)
            OWN_L:   r = 4'b0001;
            OWN_U:   r = 4'b0010;
            OWN_R:   r = 4'b0100;
            OWN_D:   r = 4'b1000;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) own_q <= OWN_NONE;
        else        own_q <= own_d;
    end

    // A fresh press always takes over; a release only matters if it was the owner
    always_comb begin
        own_d = own_q;
        if (|rise)
            own_d = pick(rise);
        else if (|(own_oh(own_q) & ~db_d))
            own_d = pick(db_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir_q     <= '0;
            dbc_dly_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            dir_q     <= own_oh(own_q);
            dbc_dly_q <= db_q[4];
            pulse_q   <= db_q[4] & ~dbc_dly_q;
        end
    end

    assign bus.Left        = dir_q[0];
    assign bus.Up          = dir_q[1];
    assign bus.Right       = dir_q[2];
    assign bus.Down        = dir_q[3];
    assign bus.centerPulse = pulse_q;
endmodule

// File: tb/tb_direction_input_ctrl.sv
// Bench for direction_input_ctrl: reference model feeds a scoreboard queue, monitor pops
// and compares every cycle; directed latency checks plus a random press/release phase.
module tb_direction_input_ctrl;
    localparam int D   = 4;
    localparam int LAT = 2 + D + 1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] btn   = '0;
    int         checks = 0;
    int         fails  = 0;
    int         pulses = 0;

    direction_input_ctrl_if bus();
    assign bus.BtnL = btn[0];
    assign bus.BtnU = btn[1];
    assign bus.BtnR = btn[2];
    assign bus.BtnD = btn[3];
    assign bus.BtnC = btn[4];

    direction_input_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [4:0] dout;
    assign dout = {bus.centerPulse, bus.Down, bus.Right, bus.Up, bus.Left};

    // Reference model: raw -> 2-edge delay -> level flips after D consecutive differing
    // samples -> owner = most recent press (ties L>U>R>D), fallback to held on release.
    logic [31:0] hist [5];
    int          nval [5];
    logic [4:0]  mdb = '0, s0 = '0, s1 = '0;
    logic        mc_last = 1'b0;
    int          ownr = -1;
    logic [4:0]  exp_q[$];

    function automatic logic [3:0] oh(input int o);
        logic [3:0] r;
        r = '0;
        if (o >= 0) r[o] = 1'b1;
        return r;
    endfunction

    function automatic int lowest(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 3; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 5; i++) begin
            hist[i] = '0;
            nval[i] = 0;
        end
        mdb = '0; s0 = '0; s1 = '0; mc_last = 1'b0; ownr = -1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        logic [4:0] ndb;
        logic [3:0] rs;
        if (!rst_n) begin
            model_clear();
            exp_q.delete();
            exp_q.push_back(5'b0);
        end else begin
            exp_q.push_back({mdb[4] & ~mc_last, oh(ownr)});
            mc_last = mdb[4];
            ndb = mdb;
            for (int i = 0; i < 5; i++) begin
                hist[i] = {hist[i][30:0], s1[i]};
                if (nval[i] < 32) nval[i]++;
                if (nval[i] >= D && hist[i][D-1:0] == {D{~mdb[i]}}) ndb[i] = ~mdb[i];
            end
            rs = ndb[3:0] & ~mdb[3:0];
            if (rs != 0) ownr = lowest(rs);
            else if (ownr >= 0 && !ndb[ownr]) ownr = lowest(ndb[3:0]);
            mdb = ndb;
            s1  = s0;
            s0  = btn;
        end
    end

    always @(negedge clk) begin
        logic [4:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (dout !== e) begin
                fails++;
                $display("FAIL scoreboard t=%0t got %b want %b", $time, dout, e);
            end
            checks++;
            if (!$onehot0(dout[3:0])) begin
                fails++;
                $display("FAIL onehot t=%0t got %b want at most one direction", $time, dout[3:0]);
            end
            if (dout[4] === 1'b1) pulses++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [4:0] got, input logic [4:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %b want %b", nm, got, want);
        end
    endtask

    // Called #1 after an edge where an input just changed: outputs must hold for LAT
    // edges and show `want` right after the LAT-th.
    task automatic lat_check(input string nm, input logic [4:0] want);
        logic [4:0] prev;
        bit         steady;
        prev   = dout;
        steady = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            if (dout !== prev) steady = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (!steady || dout !== want) begin
            fails++;
            $display("FAIL %s early=%0d got %b want %b", nm, !steady, dout, want);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        tick(3);
        check("reset_state", dout, 5'b00000);
        rst_n = 1'b1;
        tick(6);

        btn[0] = 1'b1;
        lat_check("t1_left", 5'b00001);
        tick(10);
        check("t1_hold", dout, 5'b00001);
        btn[0] = 1'b0;
        lat_check("t1_release", 5'b00000);

        for (int k = 0; k < 6; k++) begin
            btn[1] = 1'b1;
            tick($urandom_range(1, 3));
            btn[1] = 1'b0;
            tick($urandom_range(1, 3));
        end
        btn[1] = 1'b1;
        lat_check("t2_up_after_bounce", 5'b00010);
        btn[1] = 1'b0;
        lat_check("t2_release", 5'b00000);

        btn[0] = 1'b1;
        lat_check("t3_left", 5'b00001);
        btn[3] = 1'b1;
        lat_check("t3_down_preempts", 5'b01000);
        btn[3] = 1'b0;
        lat_check("t3_left_back", 5'b00001);
        btn[0] = 1'b0;
        lat_check("t3_all_off", 5'b00000);

        btn[2] = 1'b1;
        btn[1] = 1'b1;
        lat_check("t4_up_wins", 5'b00010);
        btn[1] = 1'b0;
        lat_check("t4_right_after", 5'b00100);
        btn[2] = 1'b0;
        lat_check("t4_all_off", 5'b00000);

        p0 = pulses;
        btn[4] = 1'b1;
        lat_check("t5_pulse", 5'b10000);
        check("t5_width", dout, 5'b00000);
        tick(90);
        btn[4] = 1'b0;
        tick(20);
        check("t5_pulse_count", 5'(pulses - p0), 5'd1);

        btn[0] = 1'b1;
        lat_check("t6_left", 5'b00001);
        tick(3);
        rst_n = 1'b0;
        #1;
        check("t6_async_clear", dout, 5'b00000);
        tick(2);
        rst_n = 1'b1;
        lat_check("t6_relock", 5'b00001);
        btn[0] = 1'b0;
        lat_check("t6_release", 5'b00000);

        for (int k = 0; k < 400; k++) begin
            btn = btn ^ (5'(1) << $urandom_range(0, 4));
            tick($urandom_range(1, 8));
            if ($urandom_range(0, 49) == 0) begin
                rst_n = 1'b0;
                tick(1);
                rst_n = 1'b1;
            end
        end
        btn = '0;
        tick(20);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
